// File: rtl/bus_arbiter_n.sv
// N-to-1 arbiter for CPU-side simple buses. Merges NUM_MASTERS masters
// (ibus, dbus, DMA, debug, ...) onto one downstream simple bus.
//
// Ports:
//   clk_i            clock, all state on the rising edge
//   rst_ni           synchronous active-low reset
//   m_dataenable_i   per-master byte enables, master i at [4i+3:4i]
//   m_rd_i, m_wr_i   per-master read / write request
//   m_address_i      per-master byte address, master i at [32i+31:32i]
//   m_wrdata_i       per-master write data
//   m_rddata_o       per-master read data (zero unless granted)
//   m_stall_o        per-master stall
//   s_*_o            downstream bus, driven by the granted master (zero when idle)
//   s_rddata_i       downstream read data
//   s_stall_i        downstream stall, 0 = transfer completes this cycle
//   grant_o          registered one-hot grant, all-zero when idle
//
// RR_MODE      : 0 = fixed priority (index 0 highest), 1 = round-robin from rr_ptr.
// BACK_TO_BACK : 1 = next grant issued on the completing edge, 0 = idle cycle between grants.
module bus_arbiter_n #(
    parameter int unsigned NUM_MASTERS  = 2,
    parameter int unsigned RR_MODE      = 0,
    parameter int unsigned BACK_TO_BACK = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [4*NUM_MASTERS-1:0]   m_dataenable_i,
    input  logic [NUM_MASTERS-1:0]     m_rd_i,
    input  logic [NUM_MASTERS-1:0]     m_wr_i,
    input  logic [32*NUM_MASTERS-1:0]  m_address_i,
    input  logic [32*NUM_MASTERS-1:0]  m_wrdata_i,
    output logic [32*NUM_MASTERS-1:0]  m_rddata_o,
    output logic [NUM_MASTERS-1:0]     m_stall_o,
    output logic [3:0]                 s_dataenable_o,
    output logic                       s_rd_o,
    output logic                       s_wr_o,
    output logic [31:0]                s_address_o,
    output logic [31:0]                s_wrdata_o,
    input  logic [31:0]                s_rddata_i,
    input  logic                       s_stall_i,
    output logic [NUM_MASTERS-1:0]     grant_o
);

    localparam int unsigned PtrW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef logic [NUM_MASTERS-1:0] vec_t;
    typedef logic [PtrW-1:0]        ptr_t;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e state_q, state_d;
    vec_t   grant_q, grant_d;
    ptr_t   rr_ptr_q, rr_ptr_d;

    vec_t   req;
    logic   req_g;
    ptr_t   gidx;
    ptr_t   gidx_next;

    // Lowest set bit of a vector as a one-hot.
    function automatic vec_t lowest(input vec_t mask);
        vec_t res;
        logic found;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!found && mask[i]) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

    // Selection: fixed priority picks the lowest index. Round-robin scans from
    // ptr upwards with wrap, i.e. the lowest request at or above ptr, else the
    // lowest request overall.
    function automatic vec_t pick(input vec_t mask, input ptr_t ptr);
        vec_t upper;
        upper = '0;
        if (RR_MODE == 0) begin
            return lowest(mask);
        end
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            upper[i] = mask[i] && (i >= 32'(ptr));
        end
        return (|upper) ? lowest(upper) : lowest(mask);
    endfunction

    assign req   = m_rd_i | m_wr_i;
    assign req_g = |(req & grant_q);

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                gidx = PtrW'(i);
            end
        end
    end

    assign gidx_next = (gidx == PtrW'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    grant_d = pick(req, rr_ptr_q);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!req_g) begin
                    // Master withdrew: release without touching the pointer.
                    grant_d = '0;
                    state_d = StIdle;
                end else if (!s_stall_i) begin
                    if (RR_MODE != 0) begin
                        rr_ptr_d = gidx_next;
                    end
                    if (BACK_TO_BACK != 0) begin
                        // Completing master is excluded; it re-arbitrates later.
                        grant_d = pick(req & ~grant_q, rr_ptr_q);
                        state_d = (|grant_d) ? StBusy : StIdle;
                    end else begin
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Downstream AND-OR mux on the one-hot grant; all-zero grant gives zeros.
    always_comb begin
        s_dataenable_o = '0;
        s_address_o    = '0;
        s_wrdata_o     = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            s_dataenable_o = s_dataenable_o | (m_dataenable_i[4*i +: 4] & {4{grant_q[i]}});
            s_address_o    = s_address_o | (m_address_i[32*i +: 32] & {32{grant_q[i]}});
            s_wrdata_o     = s_wrdata_o | (m_wrdata_i[32*i +: 32] & {32{grant_q[i]}});
        end
    end

    assign s_rd_o = |(m_rd_i & grant_q);
    assign s_wr_o = |(m_wr_i & grant_q);

    // Granted master sees the downstream response; other requesters are held off.
    always_comb begin
        m_stall_o  = '0;
        m_rddata_o = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            m_stall_o[i]          = grant_q[i] ? s_stall_i : req[i];
            m_rddata_o[32*i +: 32] = grant_q[i] ? s_rddata_i : 32'h0;
        end
    end

    assign grant_o = grant_q;

endmodule
